link_sync_ctrl: RTL and testbench

Byte-level link synchronization controller for the PCI physical-layer lane, running in the clk_4f domain between the serial_paralelo receiver and the upstream logic. It watches the received byte stream for COM (0xBC) idle symbols, walks a SEARCH/ALIGN/ACTIVE state machine to declare the lane active, and forwards received data only while active. It also sequences the transmit side: it drives COM idles to the serializer until the lane is active, then passes upstream data through.

---
 rtl/link_sync_ctrl.sv | 164 ++++++++++++++++
 tb/tb_link_sync_ctrl.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/link_sync_ctrl.sv
// Byte-level lane synchronization controller: hunts for COM idles, walks SEARCH/ALIGN/ACTIVE,
// forwards received data only while ACTIVE and sequences the transmit side.
module link_sync_ctrl #(
  parameter logic [7:0]  COM        = 8'hBC,
  parameter int unsigned SYNC_COUNT = 4,
  parameter int unsigned LOSS_COUNT = 3
) (
  input  logic       clk_4f,
  input  logic       reset,
  input  logic [7:0] rx_byte,
  input  logic       rx_byte_valid,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       active,
  output logic [7:0] tx_byte,
  output logic       tx_byte_valid,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic [1:0] sync_state,
  output logic [7:0] err_count
);

  localparam int unsigned SYNC_W  = (SYNC_COUNT > 1) ? $clog2(SYNC_COUNT + 1) : 1;
  localparam int unsigned LOSS_W  = (LOSS_COUNT > 1) ? $clog2(LOSS_COUNT + 1) : 1;
  localparam logic [7:0]  ERR_MAX = 8'hFF;

  typedef enum logic [1:0] {
    ST_SEARCH = 2'd0,
    ST_ALIGN  = 2'd1,
    ST_ACTIVE = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [SYNC_W-1:0] sync_cnt_q, sync_cnt_d;
  logic [LOSS_W-1:0] loss_cnt_q, loss_cnt_d;
  logic [7:0]        err_count_q, err_count_d;
  logic [7:0]        rx_data_q, rx_data_d;
  logic              rx_valid_q, rx_valid_d;
  logic [7:0]        tx_byte_q, tx_byte_d;
  logic              tx_byte_valid_q, tx_byte_valid_d;
  logic              active_q, active_d;
  logic [1:0]        sync_state_q, sync_state_d;

  // Per-cycle symbol classification
  logic              sym_com_c, sym_data_c, sym_err_c;
  logic [SYNC_W-1:0] sync_inc_c;
  logic [LOSS_W-1:0] loss_inc_c;

  assign sym_data_c = rx_byte_valid;
  assign sym_com_c  = !rx_byte_valid && (rx_byte == COM);
  assign sym_err_c  = !rx_byte_valid && (rx_byte != COM);
  assign sync_inc_c = sync_cnt_q + SYNC_W'(1);
  assign loss_inc_c = loss_cnt_q + LOSS_W'(1);

  // State register and registered outputs
  always_ff @(posedge clk_4f or negedge reset) begin
    if (!reset) begin
      state_q         <= ST_SEARCH;
      sync_cnt_q      <= '0;
      loss_cnt_q      <= '0;
      err_count_q     <= '0;
      rx_data_q       <= '0;
      rx_valid_q      <= 1'b0;
      tx_byte_q       <= COM;
      tx_byte_valid_q <= 1'b0;
      active_q        <= 1'b0;
      sync_state_q    <= 2'd0;
    end else begin
      state_q         <= state_d;
      sync_cnt_q      <= sync_cnt_d;
      loss_cnt_q      <= loss_cnt_d;
      err_count_q     <= err_count_d;
      rx_data_q       <= rx_data_d;
      rx_valid_q      <= rx_valid_d;
      tx_byte_q       <= tx_byte_d;
      tx_byte_valid_q <= tx_byte_valid_d;
      active_q        <= active_d;
      sync_state_q    <= sync_state_d;
    end
  end

  // Next-state and output logic; every decision uses the state before the edge
  always_comb begin
    state_d         = state_q;
    sync_cnt_d      = sync_cnt_q;
    loss_cnt_d      = loss_cnt_q;
    err_count_d     = err_count_q;
    rx_data_d       = rx_data_q;
    rx_valid_d      = 1'b0;
    tx_byte_d       = COM;
    tx_byte_valid_d = 1'b0;

    case (state_q)
      ST_SEARCH: begin
        if (sym_com_c) begin
          if (SYNC_COUNT == 1) begin
            state_d    = ST_ACTIVE;
            sync_cnt_d = '0;
          end else begin
            state_d    = ST_ALIGN;
            sync_cnt_d = SYNC_W'(1);
          end
        end
      end

      ST_ALIGN: begin
        if (sym_com_c) begin
          if (sync_inc_c == SYNC_W'(SYNC_COUNT)) begin
            state_d    = ST_ACTIVE;
            sync_cnt_d = '0;
          end else begin
            sync_cnt_d = sync_inc_c;
          end
        end else begin
          state_d    = ST_SEARCH;
          sync_cnt_d = '0;
        end
      end

      ST_ACTIVE: begin
        if (tx_valid) begin
          tx_byte_d       = tx_data;
          tx_byte_valid_d = 1'b1;
        end
        if (sym_data_c) begin
          rx_data_d  = rx_byte;
          rx_valid_d = 1'b1;
          loss_cnt_d = '0;
        end else if (sym_com_c) begin
          loss_cnt_d = '0;
        end else if (sym_err_c) begin
          if (err_count_q != ERR_MAX) begin
            err_count_d = err_count_q + 8'd1;
          end
          // The ERR that reaches the loss threshold still counts and drops the lane
          if (loss_inc_c == LOSS_W'(LOSS_COUNT)) begin
            state_d    = ST_SEARCH;
            loss_cnt_d = '0;
          end else begin
            loss_cnt_d = loss_inc_c;
          end
        end
      end

      default: begin
        state_d    = ST_SEARCH;
        sync_cnt_d = '0;
        loss_cnt_d = '0;
      end
    endcase

    active_d     = (state_d == ST_ACTIVE);
    sync_state_d = state_d;
  end

  assign active        = active_q;
  assign tx_byte       = tx_byte_q;
  assign tx_byte_valid = tx_byte_valid_q;
  assign rx_data       = rx_data_q;
  assign rx_valid      = rx_valid_q;
  assign sync_state    = sync_state_q;
  assign err_count     = err_count_q;

endmodule

// File: tb/tb_link_sync_ctrl.sv
// Directed bench for link_sync_ctrl: expected rx/tx bytes are queued by the driver and
// consumed by a monitor whenever the DUT raises rx_valid or tx_byte_valid.
module tb_link_sync_ctrl;

  logic       clk_4f;
  logic       reset;
  logic [7:0] rx_byte;
  logic       rx_byte_valid;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       active;
  logic [7:0] tx_byte;
  logic       tx_byte_valid;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic [1:0] sync_state;
  logic [7:0] err_count;

  int         n_checks = 0;
  int         n_fail   = 0;
  logic [7:0] rx_q[$];
  logic [7:0] tx_q[$];
  logic [7:0] mon_exp;

  link_sync_ctrl dut (
    .clk_4f        (clk_4f),
    .reset         (reset),
    .rx_byte       (rx_byte),
    .rx_byte_valid (rx_byte_valid),
    .tx_data       (tx_data),
    .tx_valid      (tx_valid),
    .active        (active),
    .tx_byte       (tx_byte),
    .tx_byte_valid (tx_byte_valid),
    .rx_data       (rx_data),
    .rx_valid      (rx_valid),
    .sync_state    (sync_state),
    .err_count     (err_count)
  );

  initial clk_4f = 1'b0;
  always #5 clk_4f = ~clk_4f;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %02h, expected %02h", name, act, exp);
    end
  endtask

  // Monitor: pops the scoreboard whenever the DUT presents a valid byte
  always @(negedge clk_4f) begin
    if (reset) begin
      if (rx_valid) begin
        if (rx_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL rx_unexpected: got rx_data %02h with nothing expected", rx_data);
        end else begin
          mon_exp = rx_q.pop_front();
          chk("rx_data", rx_data, mon_exp);
        end
      end
      if (tx_byte_valid) begin
        if (tx_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL tx_unexpected: got tx_byte %02h with nothing expected", tx_byte);
        end else begin
          mon_exp = tx_q.pop_front();
          chk("tx_byte", tx_byte, mon_exp);
        end
      end
    end
  end

  // One symbol per cycle; returns just after the edge that sampled it
  task automatic step(input logic [7:0] rb, input logic rv, input logic [7:0] td,
                      input logic tv, input bit exp_rx, input bit exp_tx);
    @(negedge clk_4f);
    rx_byte       = rb;
    rx_byte_valid = rv;
    tx_data       = td;
    tx_valid      = tv;
    if (exp_rx) rx_q.push_back(rb);
    if (exp_tx) tx_q.push_back(td);
    @(posedge clk_4f);
    #1;
  endtask

  task automatic com_seq(input string tag, input int n, input logic [7:0] last_state);
    for (int i = 0; i < n; i++) begin
      step(8'hBC, 1'b0, 8'h77, 1'b1, 1'b0, 1'b0);
      chk(tag, sync_state, (i == n - 1) ? last_state : 8'd1);
    end
  endtask

  task automatic do_reset();
    @(negedge clk_4f);
    rx_byte       = 8'h00;
    rx_byte_valid = 1'b0;
    tx_valid      = 1'b0;
    reset         = 1'b0;
    #1;
    chk("rst_state", {6'd0, sync_state}, 8'd0);
    chk("rst_active", {7'd0, active}, 8'd0);
    chk("rst_tx_byte", tx_byte, 8'hBC);
    chk("rst_rx_valid", {7'd0, rx_valid}, 8'd0);
    chk("rst_err", err_count, 8'd0);
    @(negedge clk_4f);
    reset = 1'b1;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    reset         = 1'b0;
    rx_byte       = 8'h00;
    rx_byte_valid = 1'b0;
    tx_data       = 8'h00;
    tx_valid      = 1'b0;

    // Reset, then four COMs reach ACTIVE; tx stays COM on the entering edge
    do_reset();
    chk("rst_rx_data", rx_data, 8'h00);
    chk("rst_tx_valid", {7'd0, tx_byte_valid}, 8'd0);
    com_seq("sync1_state", 4, 8'd2);
    chk("sync1_active", {7'd0, active}, 8'd1);
    chk("sync1_tx_byte", tx_byte, 8'hBC);
    chk("sync1_tx_valid", {7'd0, tx_byte_valid}, 8'd0);

    // Broken alignment returns to SEARCH without counting an error
    do_reset();
    com_seq("align_state", 2, 8'd1);
    step(8'h55, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    chk("align_break_state", {6'd0, sync_state}, 8'd0);
    chk("align_break_err", err_count, 8'd0);
    com_seq("resync_state", 4, 8'd2);
    chk("resync_active", {7'd0, active}, 8'd1);

    // Data forwarding and transmit pass-through in ACTIVE
    step(8'h12, 1'b1, 8'hA5, 1'b1, 1'b1, 1'b1);
    step(8'h34, 1'b1, 8'h00, 1'b0, 1'b1, 1'b0);
    chk("data_tx_idle", tx_byte, 8'hBC);
    step(8'hBC, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    chk("data_hold", rx_data, 8'h34);
    chk("data_hold_valid", {7'd0, rx_valid}, 8'd0);

    // Loss of sync: COM resets the loss counter, third consecutive ERR drops the lane
    step(8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    step(8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    chk("loss_err2_state", {6'd0, sync_state}, 8'd2);
    step(8'hBC, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    chk("loss_com_state", {6'd0, sync_state}, 8'd2);
    step(8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    step(8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    chk("loss_err4_state", {6'd0, sync_state}, 8'd2);
    step(8'h00, 1'b0, 8'h3C, 1'b1, 1'b0, 1'b1);
    chk("loss_drop_state", {6'd0, sync_state}, 8'd0);
    chk("loss_drop_active", {7'd0, active}, 8'd0);
    chk("loss_err_count", err_count, 8'd5);
    step(8'h00, 1'b0, 8'h99, 1'b1, 1'b0, 1'b0);
    chk("loss_tx_byte", tx_byte, 8'hBC);
    chk("loss_tx_valid", {7'd0, tx_byte_valid}, 8'd0);

    // 300 ERRs across repeated resync cycles saturate err_count
    for (int i = 0; i < 100; i++) begin
      for (int j = 0; j < 4; j++) step(8'hBC, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
      for (int j = 0; j < 3; j++) step(8'h0F, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
      if (i == 9) chk("sat_partial", err_count, 8'd35);
    end
    chk("sat_err_count", err_count, 8'd255);

    // Reset between edges in ACTIVE clears everything before the next clock
    com_seq("final_sync_state", 4, 8'd2);
    chk("reentry_err_kept", err_count, 8'd255);
    step(8'h66, 1'b1, 8'h42, 1'b1, 1'b0, 1'b0);
    chk("pre_rst_rx_valid", {7'd0, rx_valid}, 8'd1);
    chk("pre_rst_tx_byte", tx_byte, 8'h42);
    #2;
    reset = 1'b0;
    #1;
    chk("mid_rst_active", {7'd0, active}, 8'd0);
    chk("mid_rst_tx_byte", tx_byte, 8'hBC);
    chk("mid_rst_tx_valid", {7'd0, tx_byte_valid}, 8'd0);
    chk("mid_rst_rx_valid", {7'd0, rx_valid}, 8'd0);
    chk("mid_rst_err", err_count, 8'd0);
    @(negedge clk_4f);
    reset = 1'b1;
    com_seq("post_rst_state", 1, 8'd1);

    repeat (2) @(negedge clk_4f);
    chk("rx_queue_drained", 8'(rx_q.size()), 8'd0);
    chk("tx_queue_drained", 8'(tx_q.size()), 8'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
